// File: rtl/cen_pll_gen.sv
// Fractional-rate clock-enable generator: per-channel phase accumulators whose
// carries become one-cycle enable strobes, gated by a settle/lock FSM.
module cen_pll_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic [NUM_CH*ACC_W-1:0] phase,
  output logic [NUM_CH-1:0]       cen,
  output logic                    locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, LOCKED} state_t;

  state_t                  state, next_state;
  logic [ACC_W-1:0]        acc [NUM_CH];
  logic [ACC_W:0]          sum [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] shadow_inc, shadow_phase;
  logic [CNT_W-1:0]        cnt;
  logic                    cfg_change;
  logic                    running;

  always_comb begin
    cfg_change = (inc != shadow_inc) || (phase != shadow_phase);
    running    = (state == SETTLE) || (state == LOCKED);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i*ACC_W +: ACC_W]};
    end
    // Priority: run=0 first, then a config change, then normal progression.
    next_state = state;
    case (state)
      IDLE:    next_state = run ? LOAD : IDLE;
      LOAD:    next_state = run ? SETTLE : IDLE;
      SETTLE: begin
        if (!run)                                next_state = IDLE;
        else if (cfg_change)                     next_state = LOAD;
        else if (cnt == CNT_W'(LOCK_CYCLES - 1)) next_state = LOCKED;
        else                                     next_state = SETTLE;
      end
      LOCKED: begin
        if (!run)            next_state = IDLE;
        else if (cfg_change) next_state = LOAD;
        else                 next_state = LOCKED;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= IDLE;
      cen          <= '0;
      locked       <= 1'b0;
      cnt          <= '0;
      shadow_inc   <= '0;
      shadow_phase <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      state  <= next_state;
      locked <= (next_state == LOCKED);
      // Strobes are qualified by the next state so a relock or stop suppresses them.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cen[i] <= running && sum[i][ACC_W] && (next_state == LOCKED);
      end
      case (state)
        LOAD: begin
          cnt          <= '0;
          shadow_inc   <= inc;
          shadow_phase <= phase;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc[i] <= phase[i*ACC_W +: ACC_W];
          end
        end
        SETTLE: cnt <= cnt + 1'b1;
        default: ;
      endcase
      if (running) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          acc[i] <= sum[i][ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_cen_pll_gen.sv
// Directed self-checking bench for cen_pll_gen: reset, lock timing, phase,
// relock, rate/jitter and edge-case increments.
module tb_cen_pll_gen;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 64;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    run;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH*ACC_W-1:0] phase;
  logic [NUM_CH-1:0]       cen;
  logic                    locked;

  always #5 refclk = ~refclk;

  cen_pll_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .run    (run),
    .inc    (inc),
    .phase  (phase),
    .cen    (cen),
    .locked (locked)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic configure(input logic [15:0] i0, input logic [15:0] i1,
                           input logic [15:0] p0, input logic [15:0] p1);
    inc   = {i1, i0};
    phase = {p1, p0};
  endtask

  task automatic go_idle();
    run = 1'b0;
    tick();
    tick();
  endtask

  // Raise run and count edges until locked, bounded; also counts strobes seen before lock.
  task automatic lock_up(output int edges, output int early_cen);
    edges     = 0;
    early_cen = 0;
    run       = 1'b1;
    while (!locked && edges < 300) begin
      tick();
      edges++;
      if (!locked && cen != '0) early_cen++;
    end
  endtask

  int edges, early, bad, bad_per, n0, n1, t1_last, t0_last;
  int min0, max0, min1, max1, gaps;

  initial begin
    rst = 1'b1;
    run = 1'b0;
    configure(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) tick();
    check("rst_cen", cen, 0);
    check("rst_locked", locked, 0);
    rst = 1'b0;

    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (cen != '0 || locked) bad++;
    end
    check("idle_quiet", bad, 0);

    // Lock timing: LOAD + LOCK_CYCLES settle cycles, locked on the next edge after that.
    configure(16'h4000, 16'h4000, 16'h0000, 16'h8000);
    lock_up(edges, early);
    check("lock_edges", edges, LOCK_CYCLES + 2);
    check("lock_no_early_cen", early, 0);

    // Phase: ch1 (phase 0x8000) leads ch0 by exactly 2 cycles, period 4.
    bad = 0; bad_per = 0; n0 = 0; t1_last = -1; t0_last = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (cen[1]) t1_last = t;
      if (cen[0]) begin
        n0++;
        if (t1_last >= 0 && t - t1_last != 2) bad++;
        if (t0_last >= 0 && t - t0_last != 4) bad_per++;
        t0_last = t;
      end
    end
    check("phase_ch0_count", n0, 10);
    check("phase_offset_bad", bad, 0);
    check("phase_period_bad", bad_per, 0);

    // Relock on ch0 increment change.
    configure(16'h2000, 16'h4000, 16'h0000, 16'h8000);
    tick();
    check("relock_drop_locked", locked, 0);
    check("relock_drop_cen", cen, 0);
    lock_up(edges, early);
    check("relock_edges", edges, LOCK_CYCLES + 1);
    check("relock_no_cen", early, 0);
    n0 = 0; bad_per = 0; t0_last = -1;
    for (int t = 0; t < 48; t++) begin
      tick();
      if (cen[0]) begin
        n0++;
        if (t0_last >= 0 && t - t0_last != 8) bad_per++;
        t0_last = t;
      end
    end
    check("relock_ch0_count", n0, 6);
    check("relock_period8_bad", bad_per, 0);

    run = 1'b0;
    tick();
    check("run_drop_locked", locked, 0);
    check("run_drop_cen", cen, 0);
    tick();

    // Rates: 0x6666 -> 0.4 per cycle, 0x3333 -> 0.2 per cycle.
    configure(16'h6666, 16'h3333, 16'h0, 16'h0);
    lock_up(edges, early);
    n0 = 0; n1 = 0; t0_last = -1; t1_last = -1;
    min0 = 99; max0 = 0; min1 = 99; max1 = 0;
    for (int t = 0; t < 5000; t++) begin
      tick();
      if (cen[0]) begin
        n0++;
        if (t0_last >= 0) begin
          if (t - t0_last < min0) min0 = t - t0_last;
          if (t - t0_last > max0) max0 = t - t0_last;
        end
        t0_last = t;
      end
      if (cen[1]) begin
        n1++;
        if (t1_last >= 0) begin
          if (t - t1_last < min1) min1 = t - t1_last;
          if (t - t1_last > max1) max1 = t - t1_last;
        end
        t1_last = t;
      end
    end
    check("rate_ch0", (n0 >= 1999 && n0 <= 2001) ? 2000 : n0, 2000);
    check("rate_ch1", (n1 >= 999 && n1 <= 1001) ? 1000 : n1, 1000);
    check("min_gap_ch0", min0, 2);
    check("min_gap_ch1", min1, 5);
    check("jitter_ch0", (max0 - min0 <= 1) ? 0 : max0 - min0, 0);
    check("jitter_ch1", (max1 - min1 <= 1) ? 0 : max1 - min1, 0);

    // Edge increments: ch0 inc=0 never strobes; ch1 inc=0xFFFF from phase 200
    // misses exactly once (when its accumulator passes 0) in this window.
    go_idle();
    configure(16'h0000, 16'hFFFF, 16'h0000, 16'd200);
    lock_up(edges, early);
    n0 = 0; gaps = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (cen[0]) n0++;
      if (!cen[1]) gaps++;
    end
    check("inc0_no_strobe", n0, 0);
    check("incmax_gaps", gaps, 1);

    rst = 1'b1;
    tick();
    check("rst_mid_cen", cen, 0);
    check("rst_mid_locked", locked, 0);
    rst = 1'b0;
    lock_up(edges, early);
    check("post_rst_lock_edges", edges, LOCK_CYCLES + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
